// File: rtl/cursor_nav.sv
// rtl/cursor_nav.sv - board cursor stepped by synchronised, edge-detected direction keys
// Define CURSOR_AUTOREPEAT_EN to add hold-to-repeat stepping.
module cursor_nav #(
   parameter int COLS         = 8,
   parameter int ROWS         = 8,
   parameter int XW           = 3,
   parameter int YW           = 3,
   parameter bit WRAP         = 1'b1,
   parameter int SYNC_STAGES  = 2,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    input_keys,
   input  logic          home,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          moved
);
   localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

   logic [3:0]    r_sync [SYNC_STAGES];
   logic [3:0]    r_last;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_moved;
   logic [3:0]    w_ks;
   logic [3:0]    w_press;
   logic [3:0]    w_step;
   logic [XW-1:0] w_x_next;
   logic [YW-1:0] w_y_next;

   // Reset to all-ones so a key held through reset release never looks like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'b1111;
         r_last <= 4'b1111;
      end else begin
         r_sync[0] <= input_keys;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_last <= w_ks;
      end
   end

   assign w_ks    = r_sync[SYNC_STAGES-1];
   assign w_press = w_ks & ~r_last;

`ifdef CURSOR_AUTOREPEAT_EN
   localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

   logic [CW-1:0] r_rep_cnt;
   logic          r_rep_phase;
   logic          w_rep_arm;
   logic          w_rep_fire;
   logic [CW-1:0] w_rep_cnt_inc;
   logic [CW-1:0] w_rep_limit;

   // Phase 0 waits out the initial delay; phase 1 repeats at the steady rate.
   assign w_rep_arm     = !home && (w_ks == r_last) && $onehot(w_ks);
   assign w_rep_cnt_inc = r_rep_cnt + CW'(1);
   assign w_rep_limit   = r_rep_phase ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
   assign w_rep_fire    = w_rep_arm && (w_rep_cnt_inc == w_rep_limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
      end else if (!w_rep_arm) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b1;
      end else begin
         r_rep_cnt   <= w_rep_cnt_inc;
      end
   end

   assign w_step = w_press | (w_rep_fire ? w_ks : 4'b0000);
`else
   logic w_unused_repeat_cfg;
   assign w_unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
   assign w_step = w_press;
`endif

   // Opposing keys on one axis cancel; the two axes resolve independently.
   always_comb begin
      w_x_next = r_x;
      w_y_next = r_y;
      if (home) begin
         w_x_next = '0;
         w_y_next = '0;
      end else begin
         if (w_step[3] && !w_step[2]) begin
            if (r_x == X_MAX) w_x_next = WRAP ? '0 : r_x;
            else              w_x_next = r_x + XW'(1);
         end else if (w_step[2] && !w_step[3]) begin
            if (r_x == '0)    w_x_next = WRAP ? X_MAX : r_x;
            else              w_x_next = r_x - XW'(1);
         end
         if (w_step[1] && !w_step[0]) begin
            if (r_y == Y_MAX) w_y_next = WRAP ? '0 : r_y;
            else              w_y_next = r_y + YW'(1);
         end else if (w_step[0] && !w_step[1]) begin
            if (r_y == '0)    w_y_next = WRAP ? Y_MAX : r_y;
            else              w_y_next = r_y - YW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x     <= '0;
         r_y     <= '0;
         r_moved <= 1'b0;
      end else begin
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_moved <= (w_x_next != r_x) || (w_y_next != r_y);
      end
   end

   assign x     = r_x;
   assign y     = r_y;
   assign moved = r_moved;
endmodule

// File: tb/tb_cursor_nav.sv
// tb/tb_cursor_nav.sv - bench for cursor_nav on three board shapes against an arithmetic model
module tb_cursor_nav;
   localparam int N      = 2;
   localparam int RDELAY = 10;
   localparam int RRATE  = 4;
`ifdef CURSOR_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic [3:0] keys = 4'b0000;
   logic       home = 1'b0;
   logic [2:0] xa, ya, xb, yb, xc;
   logic [1:0] yc;
   logic       ma, mb, mc;

   int vectors = 0;
   int miscompares = 0;

   int cols [3] = '{8, 5, 6};
   int rows [3] = '{8, 6, 3};
   bit wrp  [3] = '{1'b1, 1'b1, 1'b0};
   logic [3:0] kq [$];
   logic [3:0] m_last;
   int         m_hold;
   int         mx [3];
   int         my [3];
   bit         mm [3];

   logic [31:0] obs_x [3];
   logic [31:0] obs_y [3];
   logic        obs_m [3];

   always #5 clk = ~clk;

   cursor_nav #(.COLS(8), .ROWS(8), .XW(3), .YW(3), .WRAP(1'b1), .SYNC_STAGES(N),
                .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE))
   u_a (.clk(clk), .rst(rst), .input_keys(keys), .home(home), .x(xa), .y(ya), .moved(ma));

   cursor_nav #(.COLS(5), .ROWS(6), .XW(3), .YW(3), .WRAP(1'b1), .SYNC_STAGES(N),
                .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE))
   u_b (.clk(clk), .rst(rst), .input_keys(keys), .home(home), .x(xb), .y(yb), .moved(mb));

   cursor_nav #(.COLS(6), .ROWS(3), .XW(3), .YW(2), .WRAP(1'b0), .SYNC_STAGES(N),
                .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE))
   u_c (.clk(clk), .rst(rst), .input_keys(keys), .home(home), .x(xc), .y(yc), .moved(mc));

   always_comb begin
      obs_x[0] = 32'(xa); obs_y[0] = 32'(ya); obs_m[0] = ma;
      obs_x[1] = 32'(xb); obs_y[1] = 32'(yb); obs_m[1] = mb;
      obs_x[2] = 32'(xc); obs_y[2] = 32'(yc); obs_m[2] = mc;
   end

   task automatic model_reset();
      kq.delete();
      for (int i = 0; i < N; i++) kq.push_back(4'b1111);
      m_last = 4'b1111;
      m_hold = 0;
      for (int i = 0; i < 3; i++) begin
         mx[i] = 0; my[i] = 0; mm[i] = 1'b0;
      end
   endtask

   // One clock edge: the key vector seen by the stepper is the raw sample from N edges ago.
   task automatic tick();
      logic [3:0] ks, st;
      int ddx, ddy, nx, ny;
      @(posedge clk);
      ks = kq.pop_front();
      kq.push_back(keys);
      st = ks & ~m_last;
      if (AR) begin
         if (!home && ks == m_last && $countones(ks) == 1) m_hold++;
         else m_hold = 0;
         if (m_hold == RDELAY || (m_hold > RDELAY && (m_hold - RDELAY) % RRATE == 0)) st = ks;
      end
      m_last = ks;
      ddx = int'(st[3]) - int'(st[2]);
      ddy = int'(st[1]) - int'(st[0]);
      for (int i = 0; i < 3; i++) begin
         if (home) begin
            nx = 0; ny = 0;
         end else begin
            nx = mx[i] + ddx;
            ny = my[i] + ddy;
            if (wrp[i]) begin
               nx = (nx + cols[i]) % cols[i];
               ny = (ny + rows[i]) % rows[i];
            end else begin
               if (nx < 0 || nx >= cols[i]) nx = mx[i];
               if (ny < 0 || ny >= rows[i]) ny = my[i];
            end
         end
         mm[i] = (nx != mx[i]) || (ny != my[i]);
         mx[i] = nx;
         my[i] = ny;
      end
      #1;
   endtask

   task automatic do_reset(input bit idle);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      if (idle) begin
         keys = 4'b0000;
         repeat (N + 1) tick();
      end
   endtask

   task automatic pulse(input logic [3:0] k);
      keys = k;
      tick();
      keys = 4'b0000;
      repeat (N + 1) tick();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++; if ({xa, ya, ma} !== 7'd0) begin miscompares++; $display("FAIL reset_a: got %b expected 0", {xa, ya, ma}); end
      vectors++; if ({xb, yb, mb} !== 7'd0) begin miscompares++; $display("FAIL reset_b: got %b expected 0", {xb, yb, mb}); end
      vectors++; if ({xc, yc, mc} !== 6'd0) begin miscompares++; $display("FAIL reset_c: got %b expected 0", {xc, yc, mc}); end
      rst = 1'b1;
      model_reset();
      repeat (N + 1) tick();
      pulse(4'b1010);
      vectors++; if ({xa, ya} !== {3'd1, 3'd1}) begin miscompares++; $display("FAIL pre_async: got %0d,%0d expected 1,1", xa, ya); end
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      vectors++; if ({xa, ya, xb, yb} !== 12'd0) begin miscompares++; $display("FAIL async_clear: got %h expected 0", {xa, ya, xb, yb}); end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (N + 1) tick();
   endtask

   task automatic test_press_latency();
      do_reset(1'b1);
      for (int p = 0; p < 3; p++) begin
         keys = 4'b1000;
         tick();
         vectors++; if (ma !== 1'b0) begin miscompares++; $display("FAIL lat_early p%0d: got %b expected 0", p, ma); end
         keys = 4'b0000;
         for (int c = 1; c <= N; c++) begin
            tick();
            vectors++; if (ma !== (c == N)) begin miscompares++; $display("FAIL lat_moved p%0d c%0d: got %b expected %b", p, c, ma, c == N); end
         end
         tick();
         vectors++; if (ma !== 1'b0) begin miscompares++; $display("FAIL lat_single p%0d: got %b expected 0", p, ma); end
      end
      vectors++; if ({xa, ya} !== {3'd3, 3'd0}) begin miscompares++; $display("FAIL three_right: got %0d,%0d expected 3,0", xa, ya); end
   endtask

   task automatic test_wrap();
      do_reset(1'b1);
      repeat (4) pulse(4'b1000);
      vectors++; if (xb !== 3'd4) begin miscompares++; $display("FAIL wrap_b_x4: got %0d expected 4", xb); end
      pulse(4'b1000);
      vectors++; if (xb !== 3'd0) begin miscompares++; $display("FAIL wrap_right: got %0d expected 0", xb); end
      vectors++; if (xa !== 3'd5) begin miscompares++; $display("FAIL wrap_a_x5: got %0d expected 5", xa); end
      pulse(4'b0100);
      vectors++; if (xb !== 3'd4) begin miscompares++; $display("FAIL wrap_left: got %0d expected 4", xb); end
      pulse(4'b0001);
      vectors++; if (yb !== 3'd5) begin miscompares++; $display("FAIL wrap_up_b: got %0d expected 5", yb); end
      vectors++; if (ya !== 3'd7) begin miscompares++; $display("FAIL wrap_up_a: got %0d expected 7", ya); end
   endtask

   task automatic test_clamp();
      int pulses;
      do_reset(1'b1);
      keys = 4'b0101;
      for (int t = 0; t < N + 3; t++) begin
         tick();
         keys = 4'b0000;
         vectors++; if ({xc, yc, mc} !== 6'd0) begin miscompares++; $display("FAIL clamp_hold t%0d: got %b expected 0", t, {xc, yc, mc}); end
      end
      pulses = 0;
      keys = 4'b1000;
      for (int t = 0; t < N + 3; t++) begin
         tick();
         keys = 4'b0000;
         pulses += int'(mc);
      end
      vectors++; if (pulses !== 1 || xc !== 3'd1) begin miscompares++; $display("FAIL clamp_right: got x=%0d pulses=%0d expected x=1 pulses=1", xc, pulses); end
      repeat (6) pulse(4'b1000);
      vectors++; if (xc !== 3'd5) begin miscompares++; $display("FAIL clamp_xmax: got %0d expected 5", xc); end
      repeat (4) pulse(4'b0010);
      vectors++; if (yc !== 2'd2) begin miscompares++; $display("FAIL clamp_ymax: got %0d expected 2", yc); end
   endtask

   task automatic test_conflict();
      int pulses;
      do_reset(1'b1);
      pulses = 0;
      keys = 4'b1011;
      for (int t = 0; t < N + 3; t++) begin
         tick();
         keys = 4'b0000;
         pulses += int'(ma);
      end
      vectors++; if ({xa, ya} !== {3'd1, 3'd0} || pulses !== 1) begin miscompares++; $display("FAIL conflict: got %0d,%0d pulses=%0d expected 1,0 pulses=1", xa, ya, pulses); end
   endtask

   task automatic test_reset_hold();
      do_reset(1'b1);
      keys = 4'b0010;
      repeat (N + 2) tick();
      do_reset(1'b0);
      for (int t = 0; t < N + 3; t++) begin
         tick();
         vectors++; if ({xa, ya, ma} !== 7'd0) begin miscompares++; $display("FAIL held_through_reset t%0d: got %b expected 0", t, {xa, ya, ma}); end
      end
      keys = 4'b0000;
      repeat (N + 1) tick();
      pulse(4'b0010);
      vectors++; if ({xa, ya} !== {3'd0, 3'd1}) begin miscompares++; $display("FAIL repress_after_reset: got %0d,%0d expected 0,1", xa, ya); end
   endtask

   task automatic test_home();
      do_reset(1'b1);
      repeat (2) pulse(4'b1000);
      repeat (3) pulse(4'b0010);
      vectors++; if ({xa, ya} !== {3'd2, 3'd3}) begin miscompares++; $display("FAIL home_setup: got %0d,%0d expected 2,3", xa, ya); end
      home = 1'b1;
      tick();
      vectors++; if ({xa, ya, ma} !== {3'd0, 3'd0, 1'b1}) begin miscompares++; $display("FAIL home_move: got %0d,%0d,%b expected 0,0,1", xa, ya, ma); end
      home = 1'b0;
      tick();
      vectors++; if (ma !== 1'b0) begin miscompares++; $display("FAIL home_pulse_len: got %b expected 0", ma); end
      home = 1'b1;
      tick();
      home = 1'b0;
      vectors++; if (ma !== 1'b0) begin miscompares++; $display("FAIL home_at_origin: got %b expected 0", ma); end
   endtask

   task automatic test_autorepeat();
      int r, pulses;
      do_reset(1'b1);
      keys = 4'b1000;
      for (int t = 0; t < N + 28; t++) begin
         tick();
         r = t - N;
         vectors++;
         if (ma !== (r == 0 || r == 10 || r == 14 || r == 18 || r == 22 || r == 26)) begin
            miscompares++; $display("FAIL repeat_step t%0d: got %b", t, ma);
         end
      end
      vectors++; if (xa !== 3'd6) begin miscompares++; $display("FAIL repeat_x: got %0d expected 6", xa); end
      keys = 4'b1100;
      pulses = 0;
      repeat (40) begin
         tick();
         pulses += int'(ma);
      end
      vectors++; if (pulses !== 1 || xa !== 3'd5) begin miscompares++; $display("FAIL repeat_stop: got x=%0d pulses=%0d expected x=5 pulses=1", xa, pulses); end
      keys = 4'b0000;
   endtask

   task automatic test_random();
      do_reset(1'b1);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 11) == 0) begin
            if ($urandom_range(0, 1) == 0) keys = 4'(1 << $urandom_range(0, 3));
            else keys = 4'($urandom);
         end
         home = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 399) == 0) begin
            home = 1'b0;
            do_reset(1'b0);
         end
         tick();
         for (int i = 0; i < 3; i++) begin
            vectors++; if (obs_x[i] !== 32'(mx[i])) begin miscompares++; $display("FAIL rand_x dut%0d cyc%0d: got %0d expected %0d", i, c, obs_x[i], mx[i]); end
            vectors++; if (obs_y[i] !== 32'(my[i])) begin miscompares++; $display("FAIL rand_y dut%0d cyc%0d: got %0d expected %0d", i, c, obs_y[i], my[i]); end
            vectors++; if (obs_m[i] !== mm[i]) begin miscompares++; $display("FAIL rand_moved dut%0d cyc%0d: got %b expected %b", i, c, obs_m[i], mm[i]); end
         end
      end
      home = 1'b0;
      keys = 4'b0000;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_press_latency();
      test_wrap();
      test_clamp();
      test_conflict();
      test_reset_hold();
      test_home();
      if (AR) test_autorepeat();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
